// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
//
// Contents:
//   arb_state_e  arbitration FSM state (ARB_IDLE, ARB_LOCK1)
//   ARB_P0/ARB_P1  port index constants (0 = CPU bus, 1 = loader/DMA)
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_LOCK1 = 1'b1
    } arb_state_e;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signal bundle of the memory arbiter
//
// Signals:
//   p0_*/p1_*    requester side: req, we, addr, wdata in; gnt, rvalid, rdata out (p1_lock port 1 only)
//   mem_*        memory side: rd_enable, wr_enable, addr, wr_data out; rd_data in
// Modports:
//   slave   the arbiter
//   master  the requesters together with the memory block
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  p0_req;
    logic                  p0_we;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_gnt;
    logic                  p0_rvalid;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_req;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_lock;
    logic                  p1_gnt;
    logic                  p1_rvalid;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic                  mem_rd_enable;
    logic                  mem_wr_enable;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_rd_enable, mem_wr_enable, mem_addr, mem_wr_data,
        output mem_rd_data
    );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational 2-way grant picker
//
// Ports:
//   req   in  2  request vector, bit N = port N
//   pref  in  1  preferred port index
//   gnt   out 2  one-hot (or zero) grant; preferred port wins when requesting
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pref,
    output logic [1:0] gnt
);

    logic other;

    assign other = ~pref;

    always_comb begin
        gnt = 2'b00;
        if (req[pref]) begin
            gnt[pref] = 1'b1;
        end else if (req[other]) begin
            gnt[other] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter in front of a single-port BRAM
//
// Ports:
//   clk       in  system clock, rising edge
//   reset_n   in  asynchronous active-low reset
//   bus       mem_arbiter_if.slave: requester handshakes, port-1 lock, memory mux and read return
// Build option:
//   MEM_ARB_RR_EN  defined -> round-robin preference in IDLE; undefined -> fixed p0 priority
// Port 0 normally wins; port 1 is forced through after MAX_WAIT consecutive denied cycles.
// A port-1 grant with p1_lock held enters LOCK1, where only port 1 can be granted, for at
// most MAX_LOCK cycles; the timeout cycle arbitrates as IDLE with port 0 preferred.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 15,
    parameter int MAX_LOCK   = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    localparam int LOCK_W = $clog2(MAX_LOCK + 1);

    arb_state_e          state;
    arb_state_e          state_next;
    logic [7:0]          wait_cnt;
    logic [7:0]          wait_next;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [LOCK_W-1:0]   lock_next;

    logic                lock_timeout;
    logic                lock_hold;
    logic                starve;
    logic                pref;
    logic [1:0]          req_vec;
    logic [1:0]          gnt;
    logic                p0_rvalid_q;
    logic                p1_rvalid_q;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_d;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;
`endif

    assign lock_timeout = (state == ARB_LOCK1) && (lock_cnt >= LOCK_W'(MAX_LOCK));
    // While the lock holds, port 0 is masked out entirely rather than merely deprioritised.
    assign lock_hold    = (state == ARB_LOCK1) && bus.p1_lock && !lock_timeout;
    assign starve       = (wait_cnt >= 8'(MAX_WAIT));

    always_comb begin
        pref = ARB_P0;
        if (lock_hold) begin
            pref = ARB_P1;
        end else if (lock_timeout) begin
            pref = ARB_P0;
        end else if (starve) begin
            pref = ARB_P1;
        end else begin
`ifdef MEM_ARB_RR_EN
            pref = rr_ptr;
`else
            pref = ARB_P0;
`endif
        end
    end

    // Reset gates the requests so grants and memory enables drop immediately.
    assign req_vec = {bus.p1_req, bus.p0_req & ~lock_hold} & {2{reset_n}};

    mem_arb_pick u_pick (
        .req  (req_vec),
        .pref (pref),
        .gnt  (gnt)
    );

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        lock_next  = '0;
        case (state)
            ARB_IDLE: begin
                if (gnt[1] && bus.p1_lock) begin
                    state_next = ARB_LOCK1;
                end
            end
            ARB_LOCK1: begin
                // Lock release or timeout returns to IDLE; re-entry needs a fresh IDLE cycle.
                if (!lock_hold) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
        if ((state == ARB_LOCK1) && (state_next == ARB_LOCK1)) begin
            lock_next = lock_cnt + LOCK_W'(1);
        end
        if (gnt[1] || !bus.p1_req) begin
            wait_next = '0;
        end else if (!starve) begin
            wait_next = wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARB_IDLE;
            wait_cnt    <= '0;
            lock_cnt    <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_next;
            lock_cnt    <= lock_next;
            p0_rvalid_q <= gnt[0] & ~bus.p0_we;
            p1_rvalid_q <= gnt[1] & ~bus.p1_we;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Pointer moves past whichever port won an IDLE-style arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= ARB_P0;
        end else if (!lock_hold && (gnt != 2'b00)) begin
            rr_ptr <= gnt[0] ? ARB_P1 : ARB_P0;
        end
    end
`endif

    always_comb begin
        mem_en = 1'b0;
        mem_we = 1'b0;
        mem_a  = '0;
        mem_d  = '0;
        if (gnt[0]) begin
            mem_en = 1'b1;
            mem_we = bus.p0_we;
            mem_a  = bus.p0_addr;
            mem_d  = bus.p0_wdata;
        end else if (gnt[1]) begin
            mem_en = 1'b1;
            mem_we = bus.p1_we;
            mem_a  = bus.p1_addr;
            mem_d  = bus.p1_wdata;
        end
    end

    assign bus.mem_rd_enable = mem_en;
    assign bus.mem_wr_enable = mem_we;
    assign bus.mem_addr      = mem_a;
    assign bus.mem_wr_data   = mem_d;

    assign bus.p0_gnt    = gnt[0];
    assign bus.p1_gnt    = gnt[1];
    assign bus.p0_rvalid = p0_rvalid_q;
    assign bus.p1_rvalid = p1_rvalid_q;
    assign bus.p0_rdata  = bus.mem_rd_data;
    assign bus.p1_rdata  = bus.mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    logic [1:0] code;
    logic [1:0] exp_code;

    logic [7:0] mem [0:65535];

    mem_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    mem_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (16),
        .MAX_WAIT   (15),
        .MAX_LOCK   (64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_enable) begin
            if (bus.mem_wr_enable) begin
                mem[bus.mem_addr] <= bus.mem_wr_data;
            end else begin
                bus.mem_rd_data <= mem[bus.mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.p1_lock = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem[16'h0010] = 8'hA5;
        bus.mem_rd_data = '0;
        idle_inputs();

        // Reset: requests asserted but everything held off.
        reset_n = 1'b0;
        bus.p0_req = 1'b1;
        bus.p1_req = 1'b1;
        #3;
        chk("rst_p0_gnt", 32'(bus.p0_gnt), 0);
        chk("rst_p1_gnt", 32'(bus.p1_gnt), 0);
        chk("rst_mem_en", 32'(bus.mem_rd_enable), 0);
        chk("rst_rvalid", 32'({bus.p1_rvalid, bus.p0_rvalid}), 0);
        step();
        step();
        reset_n = 1'b1;
        idle_inputs();

        // 1: p0 read of 0x0010.
        step();
        bus.p0_req = 1'b1; bus.p0_addr = 16'h0010;
        @(negedge clk);
        chk("t1_p0_gnt", 32'(bus.p0_gnt), 1);
        chk("t1_p1_gnt", 32'(bus.p1_gnt), 0);
        chk("t1_mem_rd_en", 32'(bus.mem_rd_enable), 1);
        chk("t1_mem_wr_en", 32'(bus.mem_wr_enable), 0);
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'h0010);
        step();
        idle_inputs();
        @(negedge clk);
        chk("t1_p0_rvalid", 32'(bus.p0_rvalid), 1);
        chk("t1_p0_rdata", 32'(bus.p0_rdata), 32'hA5);
        chk("t1_p1_rvalid", 32'(bus.p1_rvalid), 0);
        chk("t1_idle_en", 32'(bus.mem_rd_enable), 0);
        chk("t1_idle_addr", 32'(bus.mem_addr), 0);
        step();
        @(negedge clk);
        chk("t1_rvalid_once", 32'(bus.p0_rvalid), 0);

        // 5: p0 write 0x3C to 0x1234, then p1 reads it back.
        step();
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 16'h1234; bus.p0_wdata = 8'h3C;
        @(negedge clk);
        chk("t5_p0_gnt", 32'(bus.p0_gnt), 1);
        chk("t5_mem_wr_en", 32'(bus.mem_wr_enable), 1);
        chk("t5_mem_rd_en", 32'(bus.mem_rd_enable), 1);
        chk("t5_mem_wdata", 32'(bus.mem_wr_data), 32'h3C);
        step();
        idle_inputs();
        bus.p1_req = 1'b1; bus.p1_addr = 16'h1234;
        @(negedge clk);
        chk("t5_p1_gnt", 32'(bus.p1_gnt), 1);
        chk("t5_no_wr_rvalid", 32'(bus.p0_rvalid), 0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("t5_p1_rvalid", 32'(bus.p1_rvalid), 1);
        chk("t5_p1_rdata", 32'(bus.p1_rdata), 32'h3C);

        // 2/3: both ports request every cycle.
        for (int c = 1; c <= 32; c++) begin
            step();
            bus.p0_req = 1'b1; bus.p0_addr = 16'h0010;
            bus.p1_req = 1'b1; bus.p1_addr = 16'h0020;
            @(negedge clk);
            code = {bus.p1_gnt, bus.p0_gnt};
`ifdef MEM_ARB_RR_EN
            exp_code = (c % 2 == 1) ? 2'b01 : 2'b10;
`else
            exp_code = (c % 16 == 0) ? 2'b10 : 2'b01;
`endif
            chk($sformatf("t2_grant_c%0d", c), 32'(code), 32'(exp_code));
        end
        step();
        idle_inputs();

        // 4: locked p1 write burst; p0 holds one read request from cycle 2 until granted.
        for (int c = 1; c <= 70; c++) begin
            step();
            bus.p1_req = 1'b1; bus.p1_lock = 1'b1; bus.p1_we = 1'b1;
            bus.p1_addr = 16'h2000 + 16'(c); bus.p1_wdata = 8'(c);
            bus.p0_req = (c >= 2) && (c <= 66); bus.p0_we = 1'b0; bus.p0_addr = 16'h0010;
            @(negedge clk);
            code = {bus.p1_gnt, bus.p0_gnt};
            exp_code = (c == 66) ? 2'b01 : 2'b10;
            chk($sformatf("t4_grant_c%0d", c), 32'(code), 32'(exp_code));
            if (c == 67) begin
                chk("t4_p0_rvalid", 32'(bus.p0_rvalid), 1);
                chk("t4_p0_rdata", 32'(bus.p0_rdata), 32'hA5);
            end
        end
        // Dropping p1_lock leaves LOCK1 in the same cycle, arbitrating as IDLE.
        step();
        bus.p1_lock = 1'b0; bus.p1_we = 1'b0;
        bus.p0_req = 1'b1; bus.p0_addr = 16'h0010;
        @(negedge clk);
        chk("t4_unlock_grant", 32'({bus.p1_gnt, bus.p0_gnt}), 32'b01);
        step();
        bus.p0_req = 1'b0;
        @(negedge clk);
        chk("t4_p1_after", 32'({bus.p1_gnt, bus.p0_gnt}), 32'b10);
        chk("t4_unlock_rvalid", 32'(bus.p0_rvalid), 1);
        step();
        idle_inputs();

        // 6: reset in the cycle after a read grant.
        step();
        bus.p0_req = 1'b1; bus.p0_addr = 16'h0010;
        bus.p1_req = 1'b1; bus.p1_addr = 16'h0020; bus.p1_lock = 1'b1;
        @(negedge clk);
        chk("t6_p0_gnt", 32'(bus.p0_gnt), 1);
        step();
        reset_n = 1'b0;
        bus.p0_req = 1'b0;
        @(negedge clk);
        chk("t6_rvalid_drop", 32'(bus.p0_rvalid), 0);
        chk("t6_p1_gnt", 32'(bus.p1_gnt), 0);
        chk("t6_mem_en", 32'(bus.mem_rd_enable), 0);
        chk("t6_mem_addr", 32'(bus.mem_addr), 0);
        step();
        step();
        reset_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("t6_wait_cnt", 32'(dut.wait_cnt), 0);
        chk("t6_lock_cnt", 32'(dut.lock_cnt), 0);
        chk("t6_rvalid_after", 32'(bus.p0_rvalid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
